mmu_feeder: RTL

- Sequencer in front of the 16x16 8-bit matrix multiply unit.
- Accepts weight rows and activation vectors on valid/ready streams, shifts weights into the array with the array's weight-enable, then streams activations into it.
- Captures the 16x20-bit column sums after the array latency and returns them on a backpressured result stream through a small credit-managed FIFO.

---
 rtl/mmu_feeder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mmu_feeder.sv
// mmu_feeder: weight/activation sequencer for the 16x16 MMU; results appear MMU_LAT+1 cycles after accept.
// Backpressure is credit-limited to the DEPTH-entry result FIFO; `MMU_FEEDER_PERF_EN builds the stall counter.

module mmu_feeder_fifo #(
  parameter int WIDTH = 320,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

module mmu_feeder #(
  parameter int MMU_LAT = 1,
  parameter int DEPTH   = 4,
  parameter int ROWS    = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [127:0] w_data,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_data,
  output logic         r_valid,
  input  logic         r_ready,
  output logic [319:0] r_data,
  output logic         mmu_wen,
  output logic [127:0] mmu_win,
  output logic [127:0] mmu_ain,
  input  logic [319:0] mmu_aout,
  output logic         weights_loaded,
  output logic         busy,
  output logic [31:0]  stall_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [CW:0]   CREDITS  = (CW+1)'(DEPTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE} state_t;

  state_t             state;
  logic [RW-1:0]      row_cnt;
  logic [MMU_LAT-1:0] vpipe;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        credit_used;
  logic               fifo_empty;
  logic               w_acc;
  logic               a_acc;
  logic               push;
  logic               pop;

  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};

  // Credits count results in the pipe plus FIFO occupancy, so a push can never find the FIFO full.
  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE, LOAD_W: w_ready = 1'b1;
        COMPUTE: begin
          w_ready = w_valid & (inflight == '0);
          a_ready = (credit_used < CREDITS) & ~w_valid;
        end
        default: begin
          w_ready = 1'b0;
          a_ready = 1'b0;
        end
      endcase
    end
  end

  assign w_acc   = w_valid & w_ready;
  assign a_acc   = a_valid & a_ready;
  assign mmu_wen = w_acc;
  assign mmu_win = w_acc ? w_data : '0;
  assign mmu_ain = a_acc ? a_data : '0;
  assign push    = vpipe[MMU_LAT-1];
  assign r_valid = reset_n & ~fifo_empty;
  assign pop     = r_valid & r_ready;
  assign busy    = reset_n & ((state != IDLE) | (inflight != '0) | ~fifo_empty);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      row_cnt        <= '0;
      weights_loaded <= 1'b0;
      vpipe          <= '0;
      inflight       <= '0;
    end else begin
      vpipe <= (vpipe << 1) | MMU_LAT'(a_acc);
      case ({a_acc, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      case (state)
        IDLE, COMPUTE: begin
          if (w_acc) begin
            state          <= LOAD_W;
            row_cnt        <= RW'(1);
            weights_loaded <= 1'b0;
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            if (row_cnt == LAST_ROW) begin
              state          <= COMPUTE;
              row_cnt        <= '0;
              weights_loaded <= 1'b1;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mmu_feeder_fifo #(.WIDTH(320), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (mmu_aout),
    .pop       (pop),
    .head      (r_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef MMU_FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (a_valid && !a_ready && state == COMPUTE && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
